// File: rtl/airlock_request_arbiter.sv
// Airlock request arbiter: grants one arrival or departure at a time, tracks bay
// occupancy and faults on a sequencer that never completes.
// Optional lifetime counters are built only when AIRLOCK_STATS_EN is defined.
// Without it, arriveCnt/departCnt are tied to 0.
module airlock_request_arbiter #(
  parameter int unsigned GARAGE_SIZE = 3,
  parameter int unsigned INIT_COUNT  = 0,
  parameter int unsigned TIMEOUT     = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arriveReq,
  input  logic       departReq,
  input  logic       arriveDone,
  input  logic       departDone,
  input  logic       clearFault,
  output logic       arriving,
  output logic       departCtrl,
  output logic [2:0] garageFull,
  output logic       busy,
  output logic       fault,
  output logic [7:0] arriveCnt,
  output logic [7:0] departCnt
);

  typedef enum logic [2:0] {
    StIdle,
    StArrive,
    StDepartStart,
    StDepartWait,
    StFault
  } state_e;

  localparam logic [2:0] SizeW    = 3'(GARAGE_SIZE);
  localparam logic [2:0] InitW    = 3'(INIT_COUNT);
  localparam logic [8:0] TimeoutW = 9'(TIMEOUT);

  state_e     state_q, state_d;
  logic [2:0] full_q, full_d;
  logic [7:0] cnt_q, cnt_d;
  // 1 = the last granted operation was a departure, so arrival wins the next tie.
  logic       last_dep_q, last_dep_d;
  logic       arriving_q, arriving_d;
  logic       depart_q, depart_d;
  logic       busy_q, busy_d;
  logic       fault_q, fault_d;
  logic       arrival_ok, depart_ok;
  logic       expired;

  // Next-state, occupancy, timeout and registered-output decode.
  always_comb begin
    state_d    = state_q;
    full_d     = full_q;
    cnt_d      = cnt_q;
    last_dep_d = last_dep_q;
    arrival_ok = arriveReq && (full_q < SizeW);
    depart_ok  = departReq && (full_q != 3'd0);
    // Expires on the cycle the incremented count would reach TIMEOUT.
    expired    = (({1'b0, cnt_q} + 9'd1) == TimeoutW);

    unique case (state_q)
      StIdle: begin
        if (arrival_ok && (!depart_ok || last_dep_q)) begin
          state_d    = StArrive;
          cnt_d      = '0;
          last_dep_d = 1'b0;
        end else if (depart_ok) begin
          state_d    = StDepartStart;
          cnt_d      = '0;
          last_dep_d = 1'b1;
        end
      end
      StArrive: begin
        cnt_d = cnt_q + 8'd1;
        // A done pulse on the expiry cycle still counts as completion.
        if (arriveDone) begin
          state_d = StIdle;
          if (full_q < SizeW) full_d = full_q + 3'd1;
        end else if (expired) begin
          state_d = StFault;
        end
      end
      StDepartStart: begin
        state_d = StDepartWait;
      end
      StDepartWait: begin
        cnt_d = cnt_q + 8'd1;
        if (departDone) begin
          state_d = StIdle;
          if (full_q != 3'd0) full_d = full_q - 3'd1;
        end else if (expired) begin
          state_d = StFault;
        end
      end
      StFault: begin
        if (clearFault) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    arriving_d = (state_d == StArrive);
    depart_d   = (state_d == StDepartStart);
    busy_d     = (state_d != StIdle);
    fault_d    = (state_d == StFault);
  end

  // State, occupancy and output registers; reset abandons any operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      full_q     <= InitW;
      cnt_q      <= '0;
      last_dep_q <= 1'b1;
      arriving_q <= 1'b0;
      depart_q   <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      cnt_q      <= cnt_d;
      last_dep_q <= last_dep_d;
      arriving_q <= arriving_d;
      depart_q   <= depart_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

  assign arriving   = arriving_q;
  assign departCtrl = depart_q;
  assign garageFull = full_q;
  assign busy       = busy_q;
  assign fault      = fault_q;

`ifdef AIRLOCK_STATS_EN
  logic [7:0] arr_cnt_q, dep_cnt_q;
  logic       arr_evt, dep_evt;

  assign arr_evt = (state_q == StArrive) && arriveDone;
  assign dep_evt = (state_q == StDepartWait) && departDone;

  // Lifetime completion counters; wrap 255 -> 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arr_cnt_q <= '0;
      dep_cnt_q <= '0;
    end else begin
      if (arr_evt) arr_cnt_q <= arr_cnt_q + 8'd1;
      if (dep_evt) dep_cnt_q <= dep_cnt_q + 8'd1;
    end
  end

  assign arriveCnt = arr_cnt_q;
  assign departCnt = dep_cnt_q;
`else
  assign arriveCnt = '0;
  assign departCnt = '0;
`endif

endmodule

// File: tb/tb_airlock_request_arbiter.sv
// Scoreboard bench for airlock_request_arbiter: stimulus pushes expected output
// events, a monitor pops and compares them as the DUT produces them.
module tb_airlock_request_arbiter;

  localparam int GS = 3;
  localparam int TO = 200;
`ifdef AIRLOCK_STATS_EN
  localparam int StatsOn = 1;
`else
  localparam int StatsOn = 0;
`endif

  localparam int EvArr  = 1;
  localparam int EvDep  = 2;
  localparam int EvIdle = 3;
  localparam int EvFlt  = 4;

  typedef struct {
    int kind;
    int gf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       arriveReq = 1'b0;
  logic       departReq = 1'b0;
  logic       arriveDone = 1'b0;
  logic       departDone = 1'b0;
  logic       clearFault = 1'b0;
  logic       arriving;
  logic       departCtrl;
  logic [2:0] garageFull;
  logic       busy;
  logic       fault;
  logic [7:0] arriveCnt;
  logic [7:0] departCnt;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  airlock_request_arbiter #(
    .GARAGE_SIZE(GS),
    .INIT_COUNT (0),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arriveReq (arriveReq),
    .departReq (departReq),
    .arriveDone(arriveDone),
    .departDone(departDone),
    .clearFault(clearFault),
    .arriving  (arriving),
    .departCtrl(departCtrl),
    .garageFull(garageFull),
    .busy      (busy),
    .fault     (fault),
    .arriveCnt (arriveCnt),
    .departCnt (departCnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input int g);
    exp_t e;
    e.kind = k;
    e.gf   = g;
    q.push_back(e);
  endtask

  // which: 0 = arriving, 1 = departCtrl; bounded wait for the grant.
  task automatic wait_out(input int which, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if ((which == 0) ? arriving : departCtrl) seen = 1'b1;
    end
    chk(nm, int'(seen), 1);
  endtask

  task automatic do_arrive(input int gf);
    arriveReq = 1'b1;
    push(EvArr, gf);
    wait_out(0, "arrive_grant");
    arriveReq = 1'b0;
    tick(2);
    arriveDone = 1'b1;
    push(EvIdle, (gf < GS) ? gf + 1 : gf);
    tick(1);
    arriveDone = 1'b0;
    chk("arrive_gf", garageFull, (gf < GS) ? gf + 1 : gf);
    chk("arrive_busy_low", busy, 0);
  endtask

  task automatic do_depart(input int gf);
    departReq = 1'b1;
    push(EvDep, gf);
    wait_out(1, "depart_grant");
    departReq = 1'b0;
    tick(1);
    chk("depart_pulse_width", departCtrl, 0);
    tick(1);
    departDone = 1'b1;
    push(EvIdle, (gf > 0) ? gf - 1 : 0);
    tick(1);
    departDone = 1'b0;
    chk("depart_gf", garageFull, (gf > 0) ? gf - 1 : 0);
  endtask

  // Monitor: classify output events at the falling edge and check them in order.
  initial begin
    logic arr_p, busy_p, flt_p;
    int   ev;
    exp_t e;
    arr_p  = 1'b0;
    busy_p = 1'b0;
    flt_p  = 1'b0;
    forever begin
      @(negedge clk);
      ev = 0;
      if (arriving && !arr_p) ev = EvArr;
      else if (departCtrl) ev = EvDep;
      else if (fault && !flt_p) ev = EvFlt;
      else if (!busy && busy_p) ev = EvIdle;
      arr_p  = arriving;
      busy_p = busy;
      flt_p  = fault;
      if (ev != 0) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL monitor: got event %0d garageFull=%0d, required no event", ev,
                   garageFull);
        end else begin
          e = q.pop_front();
          if (e.kind != ev || e.gf != int'(garageFull)) begin
            fails++;
            $display("FAIL monitor: got event %0d garageFull=%0d, required event %0d garageFull=%0d",
                     ev, garageFull, e.kind, e.gf);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no summary, required completion before time limit");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int cnt;
    int k;
    bit f;

    // Reset state.
    tick(2);
    chk("rst_arriving", arriving, 0);
    chk("rst_departCtrl", departCtrl, 0);
    chk("rst_garageFull", garageFull, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_arriveCnt", arriveCnt, 0);
    chk("rst_departCnt", departCnt, 0);
    rst = 1'b1;
    tick(1);

    // Departure blocked by an empty bay, then an arrival is granted.
    departReq = 1'b1;
    cnt = 0;
    repeat (20) begin
      tick(1);
      if (busy || departCtrl) cnt++;
    end
    chk("empty_depart_blocked", cnt, 0);
    arriveReq = 1'b1;
    push(EvArr, 0);
    wait_out(0, "first_arrival_grant");
    arriveReq = 1'b0;
    departReq = 1'b0;
    tick(4);
    arriveDone = 1'b1;
    push(EvIdle, 1);
    tick(1);
    arriveDone = 1'b0;
    chk("first_arrival_gf", garageFull, 1);
    chk("first_arrival_arriving_low", arriving, 0);
    chk("first_arrival_busy_low", busy, 0);

    // Stray done pulses are ignored.
    arriveDone = 1'b1;
    tick(1);
    arriveDone = 1'b0;
    departDone = 1'b1;
    tick(1);
    departDone = 1'b0;
    chk("idle_done_ignored_gf", garageFull, 1);
    chk("idle_done_ignored_busy", busy, 0);
    arriveReq = 1'b1;
    push(EvArr, 1);
    wait_out(0, "second_arrival_grant");
    arriveReq  = 1'b0;
    departDone = 1'b1;
    tick(1);
    departDone = 1'b0;
    chk("departDone_in_arrive_arriving", arriving, 1);
    chk("departDone_in_arrive_gf", garageFull, 1);
    tick(1);
    arriveDone = 1'b1;
    push(EvIdle, 2);
    tick(1);
    arriveDone = 1'b0;
    chk("second_arrival_gf", garageFull, 2);
    chk("stats_arriveCnt_2", arriveCnt, StatsOn ? 2 : 0);

    // A departure leaves lastServed = departure.
    do_depart(2);
    chk("stats_departCnt_1", departCnt, StatsOn ? 1 : 0);

    // Tie: arrival first, then the held departure.
    arriveReq = 1'b1;
    departReq = 1'b1;
    push(EvArr, 1);
    wait_out(0, "tie_arrive_first");
    chk("tie_no_depart_pulse", departCtrl, 0);
    arriveReq = 1'b0;
    tick(1);
    arriveDone = 1'b1;
    push(EvIdle, 2);
    push(EvDep, 2);
    tick(1);
    arriveDone = 1'b0;
    chk("tie_arrival_gf", garageFull, 2);
    wait_out(1, "tie_then_depart");
    departReq = 1'b0;
    tick(1);
    chk("tie_depart_pulse_width", departCtrl, 0);
    tick(1);
    departDone = 1'b1;
    push(EvIdle, 1);
    tick(1);
    departDone = 1'b0;
    chk("tie_final_gf", garageFull, 1);

    // Fill to capacity; a further arrival waits until a departure frees a bay.
    do_arrive(1);
    do_arrive(2);
    arriveReq = 1'b1;
    cnt = 0;
    repeat (10) begin
      tick(1);
      if (busy || arriving) cnt++;
    end
    chk("full_arrival_blocked", cnt, 0);
    chk("full_gf", garageFull, 3);
    departReq = 1'b1;
    push(EvDep, 3);
    wait_out(1, "full_depart_grant");
    departReq = 1'b0;
    tick(2);
    departDone = 1'b1;
    push(EvIdle, 2);
    push(EvArr, 2);
    tick(1);
    departDone = 1'b0;
    chk("full_depart_gf", garageFull, 2);
    wait_out(0, "pending_arrival_granted");
    arriveReq = 1'b0;
    tick(1);
    arriveDone = 1'b1;
    push(EvIdle, 3);
    tick(1);
    arriveDone = 1'b0;
    chk("refill_gf", garageFull, 3);

    // Done pulse on the expiry cycle completes rather than faults.
    departReq = 1'b1;
    push(EvDep, 3);
    wait_out(1, "edge_depart_grant");
    departReq = 1'b0;
    tick(200);
    chk("edge_busy_at_limit", busy, 1);
    chk("edge_no_fault_yet", fault, 0);
    departDone = 1'b1;
    push(EvIdle, 2);
    tick(1);
    departDone = 1'b0;
    chk("edge_done_no_fault", fault, 0);
    chk("edge_done_gf", garageFull, 2);

    // Arrival that never completes faults exactly TO cycles after the grant.
    arriveReq = 1'b1;
    push(EvArr, 2);
    wait_out(0, "fault_arrival_grant");
    arriveReq = 1'b0;
    push(EvFlt, 2);
    k = 0;
    f = 1'b0;
    while (!f && k < 300) begin
      tick(1);
      k++;
      if (fault) f = 1'b1;
    end
    chk("fault_latency", k, TO);
    chk("fault_gf_unchanged", garageFull, 2);
    chk("fault_busy", busy, 1);
    chk("fault_arriving_low", arriving, 0);
    arriveDone = 1'b1;
    departReq  = 1'b1;
    tick(3);
    arriveDone = 1'b0;
    departReq  = 1'b0;
    chk("fault_sticky", fault, 1);
    chk("fault_inputs_ignored_gf", garageFull, 2);
    clearFault = 1'b1;
    push(EvIdle, 2);
    tick(1);
    clearFault = 1'b0;
    chk("clear_fault_low", fault, 0);
    chk("clear_busy_low", busy, 0);

    // Asynchronous reset during DEPART_WAIT.
    departReq = 1'b1;
    push(EvDep, 2);
    wait_out(1, "reset_depart_grant");
    departReq = 1'b0;
    tick(3);
    push(EvIdle, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_gf", garageFull, 0);
    chk("async_rst_departCtrl", departCtrl, 0);
    chk("async_rst_arriving", arriving, 0);
    chk("async_rst_fault", fault, 0);
    chk("async_rst_arriveCnt", arriveCnt, 0);
    tick(1);
    rst = 1'b1;

    // 256 arrival/departure pairs wrap the lifetime counters.
    for (int i = 0; i < 256; i++) begin
      do_arrive(0);
      do_depart(1);
      if (i == 254) begin
        chk("stats_arriveCnt_255", arriveCnt, StatsOn ? 255 : 0);
        chk("stats_departCnt_255", departCnt, StatsOn ? 255 : 0);
      end
    end
    chk("stats_arriveCnt_wrap", arriveCnt, 0);
    chk("stats_departCnt_wrap", departCnt, 0);

    tick(3);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/airlock_request_arbiter.md
Name: airlock_request_arbiter

Overview:
- Upstream stage of the departure and arrival airlock sequencers.
- Accepts ship arrival/departure requests and tracks bay occupancy.
- Grants one airlock operation at a time: drives the `arriving` level and a one-cycle `departCtrl` start pulse, and publishes the `garageFull` occupancy count.
- Updates occupancy on sequencer completion; faults on a sequencer that never completes.

Parameters:
- GARAGE_SIZE, 3: bay capacity in ships; max value of garageFull.
- INIT_COUNT, 0: occupancy loaded on reset; must be ≤ GARAGE_SIZE.
- TIMEOUT, 200: cycles allowed in ARRIVE or DEPART_WAIT before FAULT; range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset; 0 = reset asserted
- arriveReq  in  1  level; ship waiting outside, held until grant
- departReq  in  1  level; ship requesting departure, held until grant
- arriveDone  in  1  one-cycle pulse; arrival sequencer finished
- departDone  in  1  one-cycle pulse; departure sequencer finished
- clearFault  in  1  level; leave FAULT
- arriving  out  1  high for the whole arrival operation
- departCtrl  out  1  one-cycle departure start pulse
- garageFull  out  3  current occupancy, 0..GARAGE_SIZE
- busy  out  1  high in any state other than IDLE
- fault  out  1  high in FAULT
- arriveCnt  out  8  lifetime arrivals (optional feature)
- departCnt  out  8  lifetime departures (optional feature)

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous):
  - state=IDLE; garageFull=INIT_COUNT; lastServed=DEPART, so arrival wins the first tie.
  - arriving, departCtrl, busy and fault are 0; timeout counter is 0; arriveCnt and departCtrl-related counters arriveCnt/departCnt are 0.
  - A reset mid-operation abandons the operation with no count change.
- State: IDLE
  - arrivalOK = arriveReq && garageFull < GARAGE_SIZE.
  - departOK = departReq && garageFull > 0.
  - Only arrivalOK: go to ARRIVE.
  - Only departOK: go to DEPART_START.
  - Both: serve the kind opposite to lastServed, then update lastServed.
  - Neither: stay in IDLE. A request blocked by a full or empty bay waits silently.
- State: ARRIVE
  - arriving=1.
  - On arriveDone: garageFull+1 and go to IDLE.
  - arriving falls on the same edge that updates garageFull.
- State: DEPART_START
  - departCtrl=1 for exactly this one cycle.
  - Always go to DEPART_WAIT next.
- State: DEPART_WAIT
  - On departDone: garageFull-1 and go to IDLE.
- Timeout:
  - The 8-bit counter clears on entry to ARRIVE or DEPART_START.
  - It increments each cycle in ARRIVE or DEPART_WAIT.
  - If it reaches TIMEOUT with no matching done pulse, go to FAULT. garageFull is unchanged.
- State: FAULT
  - fault=1, busy=1; stay until clearFault=1, then go to IDLE.
  - All requests and done pulses are ignored.
- Latency: request sampled high in IDLE gives the grant output (arriving or departCtrl) on the next clock edge.
- Done handling:
  - A done pulse outside its matching state is ignored, e.g. departDone during ARRIVE or arriveDone in IDLE.
  - A done pulse on the same cycle the timeout expires counts as completion, not fault.
- Arithmetic:
  - garageFull saturates at GARAGE_SIZE on increment and at 0 on decrement, so it never wraps.
  - arriveCnt and departCnt wrap 255→0.

Optional Feature:
- AIRLOCK_STATS_EN defined:
  - arriveCnt increments on each completed arrival.
  - departCnt increments on each completed departure.
- Not defined: arriveCnt and departCnt are constant 0 and no counter registers are built.

Test Plan:
- Reset with INIT_COUNT=0, then arriveReq=1 → arriving=1 one edge later. Pulse arriveDone after 5 cycles → garageFull=1, arriving=0, busy=0.
- garageFull=0, departReq=1 → no grant, busy stays 0 for 20 cycles. Raise arriveReq → arrival granted.
- garageFull=1 with arriveReq and departReq high together → ARRIVE first (lastServed=DEPART). After arriveDone, DEPART_START with a single departCtrl pulse. After departDone, garageFull=1.
- garageFull=3 (full), arriveReq=1 → no grant. departReq then departDone → garageFull=2, after which the pending arrival is granted.
- Arrival granted with no arriveDone → fault=1 exactly TIMEOUT (200) cycles after arriving rose, garageFull unchanged. clearFault=1 → IDLE, fault=0.
- rst=0 during DEPART_WAIT → outputs clear immediately without a clock and garageFull=INIT_COUNT. With AIRLOCK_STATS_EN, 256 arrival/departure pairs → arriveCnt=0 (wrap).
